// File: rtl/m3_pkg.sv
// Shared types and helpers for the 3-phase speed/power ramp sequencer.
package m3_pkg;

    // Sequencer states: stopped, running at the requested speed, decelerating to stop.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RAMPDN = 2'd2
    } m3State_t;

    // Step code shown while stopped: all ones at the given index width.
    function automatic logic [31:0] M3_IDLE_STEP(input int stepW);
        return (32'd1 << stepW) - 32'd1;
    endfunction

    // Geometric ramp increment: period >> shift, never less than one cycle.
    function automatic logic [31:0] m3AdjStep(input logic [31:0] period, input int shift);
        logic [31:0] q;
        q = period >> shift;
        return (q == 32'd0) ? 32'd1 : q;
    endfunction

endpackage

// File: rtl/m3_step_timer.sv
// Step period timer: counts 0..period-1, raises a terminal tick and a registered strobe.
module m3_step_timer #(
    parameter int PERIOD_W = 22
) (
    input  logic                clkI,
    input  logic                nRstI,
    input  logic                clrI,
    input  logic [PERIOD_W-1:0] periodI,
    output logic                tickO,
    output logic                stbO
);

    logic [PERIOD_W-1:0] timerReg;
    logic                stbReg;

    // Greater-or-equal compare so a period shrink below the current count ends the step at once.
    assign tickO = !clrI && (timerReg >= (periodI - PERIOD_W'(1)));
    assign stbO  = stbReg;

    // Count within the step; restart on terminal tick or while held clear.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            timerReg <= '0;
            stbReg   <= 1'b0;
        end else begin
            stbReg <= tickO;
            if (clrI || tickO) begin
                timerReg <= '0;
            end else begin
                timerReg <= timerReg + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/m3_speed_power_ramp.sv
// Speed/power ramp sequencer: FSM, geometric period ramp, saturating power and step index.
module m3_speed_power_ramp
    import m3_pkg::*;
#(
    parameter int PERIOD_W   = 22,
    parameter int PERIOD_MIN = 40,
    parameter int PERIOD_MAX = 4000000,
    parameter int RATE_SHIFT = 3,
    parameter int STEPS      = 12,
    parameter int STEP_W     = 4,
    parameter int POWER_W    = 8
) (
    input  logic                clkI,
    input  logic                nRstI,
    input  logic                startI,
    input  logic                forceStopI,
    input  logic                invRotateI,
    input  logic                freqIncI,
    input  logic                freqDecI,
    input  logic                powerIncI,
    input  logic                powerDecI,
    output logic [STEP_W-1:0]   stepO,
    output logic                stepStbO,
    output logic                runningO,
    output logic [PERIOD_W-1:0] periodO,
    output logic [POWER_W-1:0]  powerO
);

    localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] P_MAX     = PERIOD_W'(PERIOD_MAX);
    localparam logic [STEP_W-1:0]   IDLE_STEP = STEP_W'(M3_IDLE_STEP(STEP_W));
    localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(STEPS - 1);
    localparam logic [POWER_W-1:0]  POWER_TOP = '1;

    m3State_t            stateReg, stateNext;
    logic [PERIOD_W-1:0] periodReg, periodNext;
    logic [STEP_W-1:0]   stepReg, stepNext;
    logic [POWER_W-1:0]  powerReg, powerNext;
    logic                tick;
    logic                timerClr;

    // Ramp arithmetic one bit wider than the period so neither direction can wrap.
    logic [PERIOD_W:0]   adjW, upW, dnW;
    logic [PERIOD_W-1:0] slowPeriod, fastPeriod;

    assign adjW       = (PERIOD_W+1)'(m3AdjStep(32'(periodReg), RATE_SHIFT));
    assign upW        = {1'b0, periodReg} + adjW;
    assign dnW        = {1'b0, periodReg} - adjW;
    assign slowPeriod = (upW > {1'b0, P_MAX}) ? P_MAX : upW[PERIOD_W-1:0];
    assign fastPeriod = (dnW < {1'b0, P_MIN}) ? P_MIN : dnW[PERIOD_W-1:0];

    // Timer is held at zero while stopped or being force-stopped, which also kills a coincident strobe.
    assign timerClr = forceStopI || (stateReg == IDLE);

    m3_step_timer #(
        .PERIOD_W(PERIOD_W)
    ) uTimer (
        .clkI   (clkI),
        .nRstI  (nRstI),
        .clrI   (timerClr),
        .periodI(periodReg),
        .tickO  (tick),
        .stbO   (stepStbO)
    );

    // State register.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic; force stop wins over everything.
    always_comb begin
        stateNext = stateReg;
        if (forceStopI) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE:    if (startI) stateNext = RUN;
                RUN:     if (!startI) stateNext = RAMPDN;
                RAMPDN: begin
                    if (startI) begin
                        stateNext = RUN;
                    end else if (tick && (periodReg == P_MAX)) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Next period, step index and power level.
    always_comb begin
        periodNext = periodReg;
        stepNext   = stepReg;
        powerNext  = powerReg;

        if (forceStopI) begin
            powerNext = '0;
        end else if (powerIncI && !powerDecI && (powerReg != POWER_TOP)) begin
            powerNext = powerReg + POWER_W'(1);
        end else if (powerDecI && !powerIncI && (powerReg != '0)) begin
            powerNext = powerReg - POWER_W'(1);
        end

        if (!forceStopI) begin
            if (stateReg == IDLE) begin
                if (startI) begin
                    periodNext = P_MAX;
                    stepNext   = '0;
                end
            end else begin
                if (stateReg == RUN) begin
                    if (freqIncI && !freqDecI) begin
                        periodNext = fastPeriod;
                    end else if (freqDecI && !freqIncI) begin
                        periodNext = slowPeriod;
                    end
                end else if (tick) begin
                    periodNext = slowPeriod;
                end
                if (tick) begin
                    if (invRotateI) begin
                        stepNext = (stepReg == '0) ? LAST_STEP : stepReg - STEP_W'(1);
                    end else begin
                        stepNext = (stepReg == LAST_STEP) ? '0 : stepReg + STEP_W'(1);
                    end
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            periodReg <= P_MAX;
            stepReg   <= '0;
            powerReg  <= '0;
        end else begin
            periodReg <= periodNext;
            stepReg   <= stepNext;
            powerReg  <= powerNext;
        end
    end

    assign runningO = (stateReg != IDLE);
    assign stepO    = runningO ? stepReg : IDLE_STEP;
    assign periodO  = periodReg;
    assign powerO   = runningO ? powerReg : '0;

endmodule
